// File: rtl/stack_ctrl.sv
// Sequencer/arbiter for a 16-entry return-address stack shared by the core (port 0) and interrupt (port 1) paths.
// Optional macro STACK_CTRL_RR_EN replaces fixed port-1 priority with round-robin arbitration.
module stack_ctrl #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_push,
  input  logic              req0_pop,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_push,
  input  logic              req1_pop,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  input  logic              flush,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_reset,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [CNT_W-1:0]  depth,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, FLUSH} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              grant_q, grant_d;
  logic              op_push_q, op_push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pend_q, pend_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic any0, any1, pick1, grant_now;

  assign any0 = req0_push | req0_pop;
  assign any1 = req1_push | req1_pop;
  assign grant_now = (state_q == IDLE) && !(flush || pend_q) && (any0 || any1);

`ifdef STACK_CTRL_RR_EN
  // prio_q names the port that wins the next contended grant.
  logic prio_q, prio_d;

  assign pick1 = any1 & (~any0 | prio_q);

  always_comb begin
    prio_d = prio_q;
    if (grant_now) prio_d = ~pick1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`else
  assign pick1 = any1;
`endif

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    grant_d     = grant_q;
    op_push_d   = op_push_q;
    data_d      = data_q;
    pend_d      = pend_q;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush || pend_q) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
        end else if (grant_now) begin
          grant_d   = pick1;
          op_push_d = pick1 ? req1_push : req0_push;
          data_d    = pick1 ? req1_data : req0_data;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (flush) pend_d = 1'b1;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = DONE;
        if (op_push_q) begin
          if (depth_q != DEPTH_C) begin
            stk_push = 1'b1;
            depth_d  = depth_q + ONE_C;
          end else begin
            err_ovf_d = 1'b1;
            rsp_err_d = 1'b1;
          end
        end else if (depth_q != '0) begin
          // Top of stack is read before the pointer moves on this edge.
          stk_pop     = 1'b1;
          rsp_data_d  = stk_dout;
          rsp_valid_d = 1'b1;
          depth_d     = depth_q - ONE_C;
        end else begin
          rsp_data_d = '0;
          err_unf_d  = 1'b1;
          rsp_err_d  = 1'b1;
        end
      end
      DONE: begin
        if (flush) pend_d = 1'b1;
        state_d = IDLE;
      end
      FLUSH: begin
        depth_d   = '0;
        err_ovf_d = 1'b0;
        err_unf_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      grant_q     <= 1'b0;
      op_push_q   <= 1'b0;
      pend_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      grant_q     <= grant_d;
      op_push_q   <= op_push_d;
      pend_q      <= pend_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Latched push data is only consumed after EXEC is entered, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign stk_reset = reset | (state_q == FLUSH);
  assign stk_din   = data_q;
  assign req0_ack  = ack0_q;
  assign req1_ack  = ack1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign depth     = depth_q;
  assign full      = (depth_q == DEPTH_C);
  assign empty     = (depth_q == '0);
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack memory, directed vector table, corner sequences and
// randomized operations checked against a queue-based reference model.
module tb_stack_ctrl;
  localparam int DATA_W = 11;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_push, req0_pop, req1_push, req1_pop, flush;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ack, req1_ack, rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data, stk_din, stk_dout;
  logic              stk_push, stk_pop, stk_reset, full, empty, err_ovf, err_unf;
  logic [CNT_W-1:0]  depth;

  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_push(req0_push), .req0_pop(req0_pop), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_push(req1_push), .req1_pop(req1_pop), .req1_data(req1_data), .req1_ack(req1_ack),
    .flush(flush), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_reset(stk_reset), .stk_din(stk_din),
    .stk_dout(stk_dout), .depth(depth), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // Stack device driven by the controller's pins
  logic [DATA_W-1:0] mem [DEPTH];
  logic [4:0]        sp = '0;
  always @(posedge clk) begin
    if (stk_reset) sp <= '0;
    else if (stk_push && sp < 5'(DEPTH)) begin
      mem[sp[3:0]] <= stk_din;
      sp <= sp + 5'd1;
    end else if (stk_pop && sp != 0) sp <= sp - 5'd1;
  end
  assign stk_dout = (sp != 0) ? mem[sp[3:0] - 4'd1] : '0;

  int push_cnt = 0, pop_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop) pop_cnt <= pop_cnt + 1;
    if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
  end

  int n_vec = 0, n_mis = 0;

  // Reference model: a plain LIFO queue plus sticky flags
  logic [DATA_W-1:0] mq[$];
  bit m_ovf = 0, m_unf = 0;

  typedef struct {
    bit port; bit push; bit pop; logic [DATA_W-1:0] d;
    bit ev; bit ee; logic [DATA_W-1:0] ed; int edep; bit eovf; bit eunf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_op(input bit push, input logic [DATA_W-1:0] d,
                          output bit ev, output bit ee, output logic [DATA_W-1:0] ed);
    ev = 0; ee = 0; ed = '0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin ee = 1; m_ovf = 1; end
    end else if (mq.size() > 0) begin
      ed = mq.pop_back(); ev = 1;
    end else begin
      ee = 1; m_unf = 1;
    end
  endtask

  task automatic model_flush();
    mq.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic add(input bit port, input bit push, input bit pop, input logic [DATA_W-1:0] d,
                     input bit ev, input bit ee, input logic [DATA_W-1:0] ed, input int edep,
                     input bit eovf, input bit eunf);
    vec_t v;
    v = '{port, push, pop, d, ev, ee, ed, edep, eovf, eunf};
    tbl.push_back(v);
  endtask

  // Drive one request, wait for its ack, compare the response against the given expectation
  task automatic apply_check(input string nm, input bit port, input bit push, input bit pop,
                             input logic [DATA_W-1:0] d, input bit ev, input bit ee,
                             input logic [DATA_W-1:0] ed, input int edep, input bit eovf, input bit eunf);
    int lat, pb, ob;
    bit got;
    pb = push_cnt; ob = pop_cnt;
    @(negedge clk);
    if (port) begin req1_push = push; req1_pop = pop; req1_data = d; end
    else      begin req0_push = push; req0_pop = pop; req0_data = d; end
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (port ? req1_ack : req0_ack) got = 1;
    end
    if (!got) begin
      n_vec++; n_mis++;
      $display("FAIL %s.ack_timeout: no ack after %0d cycles", nm, lat);
    end else begin
      chk({nm, ".lat"}, lat, 2);
      chk({nm, ".other_ack"}, port ? req0_ack : req1_ack, 0);
      chk({nm, ".rsp_valid"}, rsp_valid, ev);
      chk({nm, ".rsp_err"}, rsp_err, ee);
      if (!push) chk({nm, ".rsp_data"}, rsp_data, ed);
      chk({nm, ".depth"}, depth, edep);
      chk({nm, ".err_ovf"}, err_ovf, eovf);
      chk({nm, ".err_unf"}, err_unf, eunf);
      chk({nm, ".push_strobes"}, push_cnt - pb, (push && !ee) ? 1 : 0);
      chk({nm, ".pop_strobes"}, pop_cnt - ob, (!push && !ee) ? 1 : 0);
    end
    req0_push = 0; req0_pop = 0; req1_push = 0; req1_pop = 0;
  endtask

  task automatic run_check(input string nm, input bit port, input bit push, input bit pop,
                           input logic [DATA_W-1:0] d);
    bit ev, ee;
    logic [DATA_W-1:0] ed;
    model_op(push, d, ev, ee, ed);
    apply_check(nm, port, push, pop, d, ev, ee, ed, mq.size(), m_ovf, m_unf);
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    @(negedge clk);
    model_flush();
  endtask

  // Both ports push together and hold; record grant order and ack cycles
  task automatic contend(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         output bit g1st, output bit g2nd, output int l1, output int l2);
    int cyc, nacks;
    g1st = 0; g2nd = 0; l1 = 0; l2 = 0;
    @(negedge clk);
    req0_push = 1; req0_data = d0; req1_push = 1; req1_data = d1;
    cyc = 0; nacks = 0;
    while (nacks < 2 && cyc < 30) begin
      @(negedge clk); cyc++;
      for (int p = 0; p < 2; p++) begin
        if (p == 0 ? req0_ack : req1_ack) begin
          if (nacks == 0) begin g1st = p[0]; l1 = cyc; end
          else            begin g2nd = p[0]; l2 = cyc; end
          nacks++;
          if (p == 0) req0_push = 0; else req1_push = 0;
          if (mq.size() < DEPTH) mq.push_back(p == 0 ? d0 : d1);
        end
      end
    end
    req0_push = 0; req1_push = 0;
    if (nacks < 2) begin
      n_vec++; n_mis++;
      $display("FAIL contend.timeout: %0d acks seen, want 2", nacks);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g1, g2, g3, g4;
    int l1, l2, l3, l4, rcnt, acnt;
    reset = 1; flush = 0;
    req0_push = 0; req0_pop = 0; req0_data = '0;
    req1_push = 0; req1_pop = 0; req1_data = '0;
    repeat (2) @(negedge clk);
    chk("rst.depth", depth, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.acks", {req0_ack, req1_ack}, 0);
    chk("rst.rsp", {rsp_valid, rsp_err}, 0);
    chk("rst.rsp_data", rsp_data, 0);
    chk("rst.errs", {err_ovf, err_unf}, 0);
    chk("rst.stk_reset", stk_reset, 1);
    reset = 0;

    // Directed table: 3 pushes, 3 pops, underflow, 17 pushes into overflow
    add(0, 1, 0, 11'h101, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 11'h202, 0, 0, 0, 2, 0, 0);
    add(0, 1, 0, 11'h303, 0, 0, 0, 3, 0, 0);
    add(0, 0, 1, 11'h000, 1, 0, 11'h303, 2, 0, 0);
    add(0, 0, 1, 11'h000, 1, 0, 11'h202, 1, 0, 0);
    add(0, 0, 1, 11'h000, 1, 0, 11'h101, 0, 0, 0);
    add(0, 0, 1, 11'h000, 0, 1, 11'h000, 0, 0, 1);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 11'(12'h400 + i), 0, 0, 0, i + 1, 0, 1);
    add(0, 1, 0, 11'h7ff, 0, 1, 0, 16, 1, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      bit ev, ee;
      logic [DATA_W-1:0] ed;
      model_op(tbl[i].push, tbl[i].d, ev, ee, ed);
      apply_check($sformatf("tbl%0d", i), tbl[i].port, tbl[i].push, tbl[i].pop, tbl[i].d,
                  tbl[i].ev, tbl[i].ee, tbl[i].ed, tbl[i].edep, tbl[i].eovf, tbl[i].eunf);
      if (i == 5) chk("tbl.empty_after_pops", empty, 1);
    end
    chk("tbl.full", full, 1);

    do_flush();
    chk("flush.depth", depth, 0);
    chk("flush.errs", {err_ovf, err_unf}, 0);

    // Contention, two rounds
    contend(11'h0a0, 11'h1a1, g1, g2, l1, l2);
    contend(11'h0b0, 11'h1b1, g3, g4, l3, l4);
    chk("contend.l1", l1, 2);
    chk("contend.l2", l2, 5);
    chk("contend.l4", l4, 5);
`ifdef STACK_CTRL_RR_EN
    chk("contend.rr_alt1", g2, ~g1);
    chk("contend.rr_alt2", g3, ~g2);
    chk("contend.rr_alt3", g4, ~g3);
`else
    chk("contend.first", g1, 1);
    chk("contend.second", g2, 0);
    chk("contend.r2_first", g3, 1);
`endif
    for (int i = 0; i < 4; i++) run_check("contend.pop", i[0], 0, 1, '0);

    // Flush pulsed during EXEC of a push at depth 5
    run_check("fx.unf", 0, 0, 1, '0);
    for (int i = 0; i < 5; i++) run_check("fx.push", 1, 1, 0, 11'(12'h050 + i));
    @(negedge clk); req0_push = 1; req0_data = 11'h066;
    @(negedge clk); flush = 1;
    chk("fx.in_exec", stk_push, 1);
    @(negedge clk); flush = 0;
    chk("fx.ack", req0_ack, 1);
    chk("fx.depth6", depth, 6);
    chk("fx.unf_before", err_unf, 1);
    req0_push = 0;
    rcnt = 0; acnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stk_reset) rcnt++;
      if (req0_ack || req1_ack) acnt++;
    end
    chk("fx.stk_reset_cycles", rcnt, 1);
    chk("fx.no_ack", acnt, 0);
    chk("fx.depth0", depth, 0);
    chk("fx.errs", {err_ovf, err_unf}, 0);
    model_flush();

    // Asynchronous reset in the middle of EXEC
    for (int i = 0; i < 3; i++) run_check("ar.push", 0, 1, 0, 11'(12'h0c1 + i));
    run_check("ar.pop", 0, 0, 1, '0);
    @(negedge clk); req0_push = 1; req0_data = 11'h0dd;
    @(negedge clk);
    chk("ar.in_exec", stk_push, 1);
    #2 reset = 1;
    #1;
    chk("ar.depth", depth, 0);
    chk("ar.acks", {req0_ack, req1_ack}, 0);
    chk("ar.rsp", {rsp_valid, rsp_err}, 0);
    chk("ar.rsp_data", rsp_data, 0);
    chk("ar.stk_reset", stk_reset, 1);
    chk("ar.stk_push", stk_push, 0);
    req0_push = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    model_flush();
    run_check("ar.pop_after", 0, 0, 1, '0);

    // Randomized operations against the reference model
    for (int i = 0; i < 250; i++) begin
      int r;
      bit port, push, pop;
      r = $urandom_range(0, 24);
      if (r == 0) begin
        do_flush();
        chk("rnd.flush_depth", depth, 0);
      end else begin
        port = 1'($urandom_range(0, 1));
        push = ($urandom_range(0, 99) < 55);
        pop  = !push || ($urandom_range(0, 3) == 0);
        run_check($sformatf("rnd%0d", i), port, push, pop, 11'($urandom));
      end
    end
    chk("never_push_and_pop", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer and arbiter in front of the 16-entry, 11-bit return-address stack. Two requesters share it: port 0 is the core call/return path and port 1 is the interrupt entry/exit path.
- Serialises push and pop operations, tracks depth, blocks overflow and underflow, and returns popped data with a response handshake.
- Owns the stack's push, pop and reset pins. Nothing else drives them.

Parameters:
- DATA_W, 11, width of stack entries and request/response data
- DEPTH, 16, number of stack entries; must be a power of two
- CNT_W, 5, depth counter width, equal to log2(DEPTH)+1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_push  in  1  port 0 push request, held until req0_ack
- req0_pop  in  1  port 0 pop request, held until req0_ack
- req0_data  in  DATA_W  port 0 push data
- req0_ack  out  1  port 0 one-cycle completion pulse
- req1_push  in  1  port 1 push request
- req1_pop  in  1  port 1 pop request
- req1_data  in  DATA_W  port 1 push data
- req1_ack  out  1  port 1 one-cycle completion pulse
- flush  in  1  one-cycle pulse; empties the stack and clears the error flags
- rsp_data  out  DATA_W  popped value, valid while rsp_valid=1
- rsp_valid  out  1  pulses together with the ack of a successful pop
- rsp_err  out  1  pulses together with the ack of a rejected operation
- stk_push  out  1  drives the stack's push pin
- stk_pop  out  1  drives the stack's pop pin
- stk_reset  out  1  drives the stack's synchronous reset pin
- stk_din  out  DATA_W  drives the stack's write data
- stk_dout  in  DATA_W  stack top-of-stack, combinational from the stack
- depth  out  CNT_W  current entry count, range 0..DEPTH
- full  out  1  depth==DEPTH
- empty  out  1  depth==0
- err_ovf  out  1  sticky: a push was rejected
- err_unf  out  1  sticky: a pop was rejected

Behaviour:
- Reset: asynchronous, active-high.
  - FSM goes to IDLE; depth=0; all acks, rsp_valid, rsp_err, err_ovf and err_unf are 0; rsp_data=0; the round-robin pointer selects port 0.
  - stk_reset = reset OR (state==FLUSH), combinational. Reset must be held across at least one clk edge so the stack pointer returns to its empty value.
- FSM has four states: IDLE, EXEC, DONE, FLUSH.
- IDLE:
  - A pending flush has highest priority and moves the FSM to FLUSH.
  - Otherwise, if any request is present, arbitrate, latch the grant, op and data, and go to EXEC.
  - Arbitration: port 1 has fixed priority over port 0.
  - If one port asserts push and pop together, push wins and pop is ignored.
- EXEC (one cycle):
  - Push, depth<DEPTH: stk_push=1, stk_din=latched data, depth+1.
  - Push, depth==DEPTH: no stk_push; set err_ovf; mark the response as an error.
  - Pop, depth>0: stk_pop=1, rsp_data<=stk_dout (captured before the pointer moves), depth-1.
  - Pop, depth==0: no stk_pop; rsp_data<=0; set err_unf; mark the response as an error.
  - Always go to DONE.
- DONE (one cycle):
  - The granted port's ack=1. rsp_valid=1 only for a successful pop; rsp_err=1 only for a rejected operation.
  - Go to IDLE. The requester must deassert its request in the cycle after ack.
- FLUSH (one cycle): stk_reset=1, depth<=0, err_ovf<=0, err_unf<=0, then go to IDLE. No ack is issued.
- A flush pulse arriving in EXEC or DONE is latched as pending and serviced in the next IDLE, ahead of any request.
- Latency: request seen in IDLE at cycle N; stack strobe in cycle N+1; ack/rsp in cycle N+2. Maximum throughput is one operation per 3 cycles.
- stk_push and stk_pop are never asserted together, and are only asserted in EXEC.
- depth never exceeds DEPTH and never wraps below 0. full and empty are combinational from depth.
- Acks, rsp_valid and rsp_err are registered outputs.

Optional Feature:
- Macro: STACK_CTRL_RR_EN.
- Defined: round-robin arbitration. On contention, grant the port not granted last. The last-granted pointer updates on each grant.
- Undefined: fixed priority, port 1 over port 0. The pointer logic is not built.

Test Plan:
- Reset then 3 pushes on port 0 (0x101, 0x202, 0x303) -> each req0_ack arrives 2 cycles after the request; depth=3; stk_push pulses exactly 3 times.
- Then 3 pops on port 0 -> rsp_data 0x303, 0x202, 0x101 with rsp_valid; depth=0; empty=1.
- Pop with depth=0 -> no stk_pop; rsp_err=1, rsp_data=0; err_unf stays 1 until flush. Then 17 pushes -> the 17th gets rsp_err; err_ovf=1; depth=16; full=1.
- req0_push and req1_push asserted in the same cycle, held:
  - Without the macro: port 1 is acked first, port 0 three cycles later.
  - With STACK_CTRL_RR_EN: grants alternate across repeated contention.
- flush pulsed during EXEC of a push at depth 5 -> the push completes (depth 6, ack given), then FLUSH: stk_reset high for 1 cycle; depth=0; err flags cleared.
- Assert reset asynchronously mid-EXEC -> depth, acks and rsp outputs are 0 immediately; stk_reset=1; after release the next pop returns rsp_err.
